// File: rtl/dram_writer.sv
// rtl/dram_writer.sv - packs a byte stream into LANES-wide DRAM write beats
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   new_addr(_valid)    base address for the next stream, loaded in IDLE only
//   byte_in/valid/ready stream input; ready only while filling a beat
//   flush               end of stream: write any partial beat, then finish
//   dram_en/rdwr        per-lane write request; rdwr=1 whenever any lane is enabled
//   dram_addr/data      per-lane byte address (cur_addr+i) and write data
//   dram_valid          per-lane completion from DRAM
//   done                one-cycle pulse once the whole stream has committed
//   bytes_written       bytes committed since the last new_addr load
module dram_writer #(
   parameter int LANES  = 8,   // power of two, >= 2
   parameter int ADDR_W = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_W-1:0]       new_addr,
   input  logic                    new_addr_valid,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   output logic                    byte_ready,
   input  logic                    flush,
   output logic [LANES-1:0]        dram_en,
   output logic                    dram_rdwr,
   output logic [LANES*ADDR_W-1:0] dram_addr,
   output logic [LANES*8-1:0]      dram_data,
   input  logic [LANES-1:0]        dram_valid,
   output logic                    done,
   output logic [ADDR_W-1:0]       bytes_written
);

   localparam int IW = $clog2(LANES);
   localparam int CW = IW + 1;   // cnt must reach LANES

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0] bytes_q, bytes_d;
   logic [LANES-1:0]  ack_q, ack_d;
   logic              flush_pend_q, flush_pend_d;
   logic [7:0]        lane_q [LANES];
   logic [7:0]        lane_d [LANES];

   logic [LANES-1:0]  lane_en;
   logic [CW-1:0]     fill_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         cur_addr_q   <= '0;
         bytes_q      <= '0;
         ack_q        <= '0;
         flush_pend_q <= 1'b0;
         for (int i = 0; i < LANES; i++) lane_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cur_addr_q   <= cur_addr_d;
         bytes_q      <= bytes_d;
         ack_q        <= ack_d;
         flush_pend_q <= flush_pend_d;
         for (int i = 0; i < LANES; i++) lane_q[i] <= lane_d[i];
      end
   end

   // Lane enables come straight from registered state so that an
   // asynchronous reset drops them immediately.
   always_comb begin
      lane_en = '0;
      for (int i = 0; i < LANES; i++)
         lane_en[i] = (state_q == S_WRITE) && (CW'(i) < cnt_q);
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cur_addr_d   = cur_addr_q;
      bytes_d      = bytes_q;
      ack_d        = ack_q;
      flush_pend_d = flush_pend_q;
      lane_d       = lane_q;
      fill_cnt     = cnt_q;
      byte_ready   = 1'b0;
      done         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (new_addr_valid) begin
               cur_addr_d   = new_addr;
               bytes_d      = '0;
               cnt_d        = '0;
               ack_d        = '0;
               flush_pend_d = 1'b0;
               state_d      = S_FILL;
            end
         end

         S_FILL: begin
            byte_ready = 1'b1;
            // A byte arriving with flush is counted before flush is applied.
            if (byte_valid) begin
               lane_d[cnt_q[IW-1:0]] = byte_in;
               fill_cnt              = cnt_q + CW'(1);
            end
            cnt_d = fill_cnt;
            if (fill_cnt == CW'(LANES)) begin
               state_d      = S_WRITE;
               flush_pend_d = flush;
            end else if (flush) begin
               if (fill_cnt != '0) begin
                  state_d      = S_WRITE;
                  flush_pend_d = 1'b1;
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_WRITE: begin
            // Sticky ack mask; completions on idle lanes are masked off.
            ack_d = ack_q | (dram_valid & lane_en);
            if (((ack_q | dram_valid) & lane_en) == lane_en) begin
               cur_addr_d   = cur_addr_q + ADDR_W'(cnt_q);
               bytes_d      = bytes_q + ADDR_W'(cnt_q);
               cnt_d        = '0;
               ack_d        = '0;
               flush_pend_d = 1'b0;
               state_d      = flush_pend_q ? S_DONE : S_FILL;
            end
         end

         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Disabled lanes drive zero so idle outputs read as all-zero.
   always_comb begin
      dram_addr = '0;
      dram_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_en[i]) begin
            dram_addr[i*ADDR_W +: ADDR_W] = cur_addr_q + ADDR_W'(i);
            dram_data[i*8 +: 8]           = lane_q[i];
         end
      end
   end

   assign dram_en       = lane_en;
   assign dram_rdwr     = |lane_en;
   assign bytes_written = bytes_q;

endmodule

// File: tb/tb_dram_writer.sv
// tb/tb_dram_writer.sv - directed table-driven bench for dram_writer
module tb_dram_writer;

   localparam int LANES  = 8;
   localparam int ADDR_W = 64;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [ADDR_W-1:0]       new_addr;
   logic                    new_addr_valid;
   logic [7:0]              byte_in;
   logic                    byte_valid;
   logic                    byte_ready;
   logic                    flush;
   logic [LANES-1:0]        dram_en;
   logic                    dram_rdwr;
   logic [LANES*ADDR_W-1:0] dram_addr;
   logic [LANES*8-1:0]      dram_data;
   logic [LANES-1:0]        dram_valid;
   logic                    done;
   logic [ADDR_W-1:0]       bytes_written;

   dram_writer #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .new_addr       (new_addr),
      .new_addr_valid (new_addr_valid),
      .byte_in        (byte_in),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .flush          (flush),
      .dram_en        (dram_en),
      .dram_rdwr      (dram_rdwr),
      .dram_addr      (dram_addr),
      .dram_data      (dram_data),
      .dram_valid     (dram_valid),
      .done           (done),
      .bytes_written  (bytes_written)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      logic [63:0] base;
      int          n;
      logic [7:0]  first;
      bit          flush_same;  // flush rides on the last byte
      int          beats;
      logic [7:0]  last_en;
      logic [63:0] last_base;
      logic [63:0] bw;
   } vec_t;

   vec_t tbl [7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] addr_lane(input int i);
      return dram_addr[i*ADDR_W +: ADDR_W];
   endfunction

   function automatic logic [7:0] data_lane(input int i);
      return dram_data[i*8 +: 8];
   endfunction

   task automatic run_stream(input vec_t v, input int k);
      int          idx, beat, wcyc, cyc, rem, flush_cyc, done_cyc;
      bit          fin, fsent;
      logic [7:0]  exp_en;
      logic [63:0] bb;
      idx = 0; beat = 0; wcyc = 0; cyc = 0; flush_cyc = 0; done_cyc = 0;
      fin = 0; fsent = 0;

      @(negedge clk);
      new_addr       = v.base;
      new_addr_valid = 1'b1;
      @(negedge clk);
      new_addr_valid = 1'b0;
      new_addr       = '0;
      check($sformatf("v%0d_ready_in_fill", k), byte_ready, 1);
      check($sformatf("v%0d_bw_cleared", k), bytes_written, 0);

      while (!fin && cyc < 300) begin
         byte_valid = 1'b0;
         flush      = 1'b0;
         dram_valid = '0;
         if (dram_en != '0) begin
            if (wcyc == 0) begin
               rem = v.n - beat * 8;
               if (rem < 0) rem = 0;
               exp_en = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
               bb     = v.base + 64'(beat * 8);
               check($sformatf("v%0d_b%0d_en", k, beat), dram_en, exp_en);
               check($sformatf("v%0d_b%0d_rdwr", k, beat), dram_rdwr, 1);
               check($sformatf("v%0d_b%0d_ready", k, beat), byte_ready, 0);
               for (int i = 0; i < LANES; i++) begin
                  if (exp_en[i]) begin
                     check($sformatf("v%0d_b%0d_addr%0d", k, beat, i), addr_lane(i), bb + 64'(i));
                     check($sformatf("v%0d_b%0d_data%0d", k, beat, i), data_lane(i), v.first + 8'(beat * 8 + i));
                  end
               end
               if (beat == v.beats - 1) begin
                  check($sformatf("v%0d_last_en", k), dram_en, v.last_en);
                  check($sformatf("v%0d_last_base", k), addr_lane(0), v.last_base);
               end
            end else begin
               dram_valid = 8'hFF;   // acks also raised on idle lanes
            end
            wcyc++;
         end else begin
            if (wcyc != 0) begin
               check($sformatf("v%0d_b%0d_write_cycles", k, beat), wcyc, 2);
               wcyc = 0;
               beat++;
            end
            if (done) begin
               fin      = 1;
               done_cyc = cyc;
            end else if (byte_ready) begin
               if (idx < v.n) begin
                  byte_in    = v.first + 8'(idx);
                  byte_valid = 1'b1;
                  if (v.flush_same && idx == v.n - 1) begin
                     flush     = 1'b1;
                     fsent     = 1;
                     flush_cyc = cyc;
                  end
                  idx++;
               end else if (!fsent) begin
                  flush     = 1'b1;
                  fsent     = 1;
                  flush_cyc = cyc;
               end
            end
         end
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end

      check($sformatf("v%0d_finished_in_budget", k), fin, 1);
      check($sformatf("v%0d_beats", k), beat, v.beats);
      check($sformatf("v%0d_bytes_written", k), bytes_written, v.bw);
      if (!v.flush_same && (v.n % 8) == 0)
         check($sformatf("v%0d_flush_to_done", k), done_cyc - flush_cyc, 1);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", k), done, 0);
      check($sformatf("v%0d_idle_ready", k), byte_ready, 0);
      check($sformatf("v%0d_bw_held", k), bytes_written, v.bw);
   endtask

   initial begin
      bit saw_done;

      tbl[0] = '{base:64'h100, n:8, first:8'h00, flush_same:0, beats:1,
                 last_en:8'hFF, last_base:64'h100, bw:64'd8};
      tbl[1] = '{base:64'h200, n:11, first:8'hA0, flush_same:0, beats:2,
                 last_en:8'h07, last_base:64'h208, bw:64'd11};
      tbl[2] = '{base:64'h280, n:0, first:8'h00, flush_same:0, beats:0,
                 last_en:8'h00, last_base:64'h0, bw:64'd0};
      tbl[3] = '{base:64'hFFFF_FFFF_FFFF_FFFC, n:8, first:8'h55, flush_same:0, beats:1,
                 last_en:8'hFF, last_base:64'hFFFF_FFFF_FFFF_FFFC, bw:64'd8};
      tbl[4] = '{base:64'h7, n:5, first:8'h10, flush_same:1, beats:1,
                 last_en:8'h1F, last_base:64'h7, bw:64'd5};
      tbl[5] = '{base:64'h300, n:16, first:8'h40, flush_same:0, beats:2,
                 last_en:8'hFF, last_base:64'h308, bw:64'd16};
      tbl[6] = '{base:64'h1000, n:9, first:8'hF0, flush_same:1, beats:2,
                 last_en:8'h01, last_base:64'h1008, bw:64'd9};

      reset          = 1'b0;
      new_addr       = '0;
      new_addr_valid = 1'b0;
      byte_in        = '0;
      byte_valid     = 1'b0;
      flush          = 1'b0;
      dram_valid     = '0;

      @(negedge clk);
      @(negedge clk);
      check("rst_en", dram_en, 0);
      check("rst_rdwr", dram_rdwr, 0);
      check("rst_addr_lo", dram_addr[63:0], 0);
      check("rst_addr_hi", dram_addr[511:448], 0);
      check("rst_data", dram_data, 0);
      check("rst_ready", byte_ready, 0);
      check("rst_done", done, 0);
      check("rst_bw", bytes_written, 0);
      reset = 1'b1;

      for (int k = 0; k < 7; k++) run_stream(tbl[k], k);

      // Staggered acks; new_addr_valid during FILL must be ignored.
      @(negedge clk);
      new_addr       = 64'h400;
      new_addr_valid = 1'b1;
      @(negedge clk);
      new_addr       = 64'hDEAD;
      byte_in        = 8'h80;
      byte_valid     = 1'b1;
      for (int j = 1; j < 8; j++) begin
         @(negedge clk);
         new_addr_valid = 1'b0;
         byte_in        = 8'h80 + 8'(j);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      check("stag_c1_en", dram_en, 8'hFF);
      check("stag_c1_addr0", addr_lane(0), 64'h400);
      check("stag_c1_data7", data_lane(7), 8'h87);
      dram_valid = 8'h0F;
      @(negedge clk);
      dram_valid = 8'h00;
      check("stag_c2_en", dram_en, 8'hFF);
      check("stag_c2_addr7", addr_lane(7), 64'h407);
      check("stag_c2_data7", data_lane(7), 8'h87);
      @(negedge clk);
      check("stag_c3_en", dram_en, 8'hFF);
      check("stag_c3_addr0", addr_lane(0), 64'h400);
      check("stag_c3_data0", data_lane(0), 8'h80);
      check("stag_c3_rdwr", dram_rdwr, 1);
      dram_valid = 8'hF0;
      @(negedge clk);
      dram_valid = 8'h00;
      check("stag_c4_en_dropped", dram_en, 8'h00);
      check("stag_c4_bw", bytes_written, 64'd8);
      check("stag_c4_ready", byte_ready, 1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("stag_done", done, 1);
      @(negedge clk);
      check("stag_done_off", done, 0);
      check("stag_bw_held", bytes_written, 64'd8);

      // Reset asserted while a full beat is being written.
      new_addr       = 64'h500;
      new_addr_valid = 1'b1;
      @(negedge clk);
      new_addr_valid = 1'b0;
      byte_valid     = 1'b1;
      for (int j = 0; j < 8; j++) begin
         byte_in = 8'hC0 + 8'(j);
         @(negedge clk);
      end
      byte_valid = 1'b0;
      check("rstw_en_before", dram_en, 8'hFF);
      #1 reset = 1'b0;
      #1;
      check("rstw_en_async_drop", dram_en, 8'h00);
      check("rstw_rdwr", dram_rdwr, 0);
      @(negedge clk);
      reset = 1'b1;
      saw_done = 0;
      byte_valid = 1'b1;   // ignored in IDLE
      flush      = 1'b1;   // ignored in IDLE
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         if (done) saw_done = 1;
      end
      byte_valid = 1'b0;
      flush      = 1'b0;
      check("rstw_no_done", saw_done, 0);
      check("rstw_idle_ready", byte_ready, 0);
      check("rstw_idle_en", dram_en, 0);
      check("rstw_bw", bytes_written, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dram_writer.md
Name: dram_writer

Overview:
- Write-direction counterpart of the fetch unit's 8-lane DRAM read path.
- Accepts a byte stream from the serializer/encoder and packs it into beats of up to 8 bytes.
- Issues write requests on the same per-lane en/rdwr/addr/data/valid DRAM interface the fetch unit reads through, starting at a programmed base address.
- Reports completion and the total byte count to the control logic.

Parameters:
LANES, 8, byte lanes per DRAM beat (power of two)
ADDR_W, 64, DRAM byte-address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
new_addr  in  ADDR_W  base address for the next stream
new_addr_valid  in  1  load new_addr; accepted only in IDLE
byte_in  in  8  stream byte
byte_valid  in  1  byte_in valid
byte_ready  out  1  writer can accept byte_in this cycle
flush  in  1  end of stream; write any partial beat, then finish
dram_en  out  LANES  per-lane request enable
dram_rdwr  out  1  1 = write; held at 1 whenever any dram_en bit is set
dram_addr  out  LANES x ADDR_W  per-lane byte address
dram_data  out  LANES x 8  per-lane write data
dram_valid  in  LANES  per-lane completion from DRAM
done  out  1  one-cycle pulse when the stream has fully committed
bytes_written  out  ADDR_W  bytes committed since the last new_addr load

Behaviour:
Reset values:
- All outputs 0; state IDLE; lane count 0; internal address 0.
- Reset asserted mid-WRITE drops dram_en immediately (asynchronously). In-flight data is discarded.

States:
- IDLE:
  - byte_ready=0.
  - new_addr_valid latches cur_addr=new_addr, clears bytes_written, and moves to FILL next cycle.
  - byte_valid and flush are ignored.
- FILL:
  - byte_ready=1.
  - byte_valid && byte_ready writes byte_in to lane `cnt`, then cnt++.
  - When the 8th byte is accepted (cnt becomes LANES), go to WRITE next cycle.
  - flush with cnt>0 goes to WRITE as a partial beat. flush with cnt==0 goes to DONE.
  - A byte and flush in the same cycle: the byte is accepted first and counts toward the beat, then the flush is applied.
- WRITE:
  - byte_ready=0.
  - dram_en[i]=1 for i<cnt; dram_rdwr=1; dram_addr[i]=cur_addr+i; dram_data[i]=lane i byte.
  - All outputs are held stable until every enabled lane has reported.
  - dram_valid bits are captured into a sticky ack mask. Valid on non-enabled lanes is ignored.
  - When (ack | dram_valid) covers all enabled lanes:
    - dram_en drops to 0 next cycle.
    - cur_addr += cnt and bytes_written += cnt (both truncate to ADDR_W).
    - cnt and the ack mask clear.
    - Next state is FILL, or DONE if this beat was produced by flush (a latched flush_pending flag).
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - bytes_written holds until the next new_addr load.

Timing and edge rules:
- Minimum latency from the 8th byte accepted to dram_en asserted: 1 cycle.
- A beat against a DRAM that answers in the next cycle occupies 2 WRITE cycles.
- Address wrap past 2^ADDR_W-1 wraps modulo 2^ADDR_W per lane. No error is raised.
- Beats are not aligned: lane i always maps to cur_addr+i.
- new_addr_valid outside IDLE is ignored.
- flush received outside FILL is ignored. The source must hold flush until it sees byte_ready.

Test Plan:
1. Reset low 2 cycles, release; new_addr=0x100; stream bytes 0x00..0x07; DRAM acks the next cycle.
   -> one beat with dram_en=0xFF, rdwr=1, addr[i]=0x100+i, data[i]=i.
   -> byte_ready=0 during the beat; bytes_written=8.
2. new_addr=0x200; 11 bytes (0xA0..0xAA) then flush.
   -> beat 1: en=0xFF, addr base 0x200.
   -> beat 2: en=0x07, addr base 0x208, data A8/A9/AA.
   -> done pulse; bytes_written=11.
3. Staggered acks: on a full beat, DRAM asserts valid lanes 0-3 in cycle 1 and lanes 4-7 in cycle 3.
   -> en/addr/data held stable through cycle 3; en drops in cycle 4.
4. flush with cnt==0 right after new_addr.
   -> no dram_en ever asserted; done pulses 1 cycle after flush; bytes_written=0.
5. Base 0xFFFF_FFFF_FFFF_FFFC; 8 bytes.
   -> addr lanes 0-3 = ...FC..FF, lanes 4-7 = 0x0..0x3.
6. Reset driven low while in WRITE with en=0xFF.
   -> dram_en=0 in the same cycle; after release, state IDLE, byte_ready=0, done never pulsed.
